// File: rtl/nios_cpu_oci_dct_packer.sv
// Packs 2-bit direct-control-transfer trace codes into 15-slot words and hands
// completed or flushed words to a single-entry frame register for the trace port.
module nios_cpu_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        trc_on,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        flush_req,
    input  logic        frame_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        frame_valid,
    output logic [33:0] frame_data,
    output logic        overflow
);

    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        fv_q, fv_d;
    logic [33:0] fd_q, fd_d;
    logic        ovf_q, ovf_d;
    logic        pend_q, pend_d;
    logic        trc_q, trc_d;

    logic frame_free;
    logic full;
    logic code_in;
    logic flush_evt;
    logic flush_any;

    always_comb begin
        frame_free = !fv_q || frame_ready;
        full       = (cnt_q == 4'd15);
        code_in    = dct_valid && trc_on;
        flush_evt  = flush_req || (trc_q && !trc_on);
        flush_any  = flush_evt || pend_q;

        buf_d  = buf_q;
        cnt_d  = cnt_q;
        fv_d   = fv_q && !frame_ready;
        fd_d   = fd_q;
        ovf_d  = ovf_q;
        pend_d = pend_q;
        trc_d  = trc_on;

        if (full && frame_free) begin
            // Full word moves out first; an incoming code starts the fresh word,
            // and any flush then refers to whatever that fresh word holds.
            fd_d  = {4'hF, buf_q};
            fv_d  = 1'b1;
            buf_d = code_in ? {28'b0, dct_code} : 30'b0;
            cnt_d = code_in ? 4'd1 : 4'd0;
            if (flush_any) begin
                pend_d = code_in;
            end
        end else if (full) begin
            if (code_in) begin
                ovf_d = 1'b1;
            end
            if (flush_evt) begin
                pend_d = 1'b1;
            end
        end else begin
            if (code_in) begin
                buf_d = {buf_q[27:0], dct_code};
                cnt_d = cnt_q + 4'd1;
            end
            // A flush sees the word including this cycle's accepted code.
            if (flush_any) begin
                if (cnt_d == 4'd0) begin
                    pend_d = 1'b0;
                end else if (frame_free) begin
                    fd_d   = {cnt_d, buf_d};
                    fv_d   = 1'b1;
                    buf_d  = 30'b0;
                    cnt_d  = 4'd0;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= 30'b0;
            cnt_q  <= 4'd0;
            fv_q   <= 1'b0;
            fd_q   <= 34'b0;
            ovf_q  <= 1'b0;
            pend_q <= 1'b0;
            trc_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            fv_q   <= fv_d;
            fd_q   <= fd_d;
            ovf_q  <= ovf_d;
            pend_q <= pend_d;
            trc_q  <= trc_d;
        end
    end

    assign dct_buffer  = buf_q;
    assign dct_count   = cnt_q;
    assign frame_valid = fv_q;
    assign frame_data  = fd_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_nios_cpu_oci_dct_packer.sv
// Bench for the trace code packer: a queue-based reference of the packing word
// and frame register, checked every cycle, plus hand-computed frame values.
module tb_nios_cpu_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        trc_on;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush_req;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic [33:0] frame_data;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    nios_cpu_oci_dct_packer dut (
        .clk         (clk),
        .reset       (reset),
        .trc_on      (trc_on),
        .dct_valid   (dct_valid),
        .dct_code    (dct_code),
        .flush_req   (flush_req),
        .frame_ready (frame_ready),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .overflow    (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0]  mq[$];
    logic        m_fv;
    logic [33:0] m_fd;
    logic        m_ovf;
    logic        m_pend;
    logic        m_trc;

    function automatic logic [29:0] pack_words();
        logic [29:0] v;
        v = '0;
        foreach (mq[i]) v = v * 4 + 30'(mq[i]);
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fv   = 1'b0;
        m_fd   = '0;
        m_ovf  = 1'b0;
        m_pend = 1'b0;
        m_trc  = 1'b0;
    endtask

    task automatic emit(input logic [3:0] n);
        m_fd = {n, pack_words()};
        m_fv = 1'b1;
        mq.delete();
    endtask

    task automatic model_step(input logic t, input logic v, input logic [1:0] c,
                              input logic f, input logic r);
        logic free, evt, code;
        free = !m_fv || r;
        evt  = f || (m_trc && !t);
        code = v && t;
        if (m_fv && r) m_fv = 1'b0;
        if (mq.size() == 15 && free) begin
            emit(4'hF);
            if (code) mq.push_back(c);
            if (evt || m_pend) m_pend = (mq.size() > 0);
        end else if (mq.size() == 15) begin
            if (code) m_ovf = 1'b1;
            if (evt) m_pend = 1'b1;
        end else begin
            if (code) mq.push_back(c);
            if (evt || m_pend) begin
                if (mq.size() == 0) m_pend = 1'b0;
                else if (free) begin
                    emit(4'(mq.size()));
                    m_pend = 1'b0;
                end else m_pend = 1'b1;
            end
        end
        m_trc = t;
    endtask

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: apply the edge to the model, then check just after it.
    always @(posedge clk) begin
        logic s_rst, s_t, s_v, s_f, s_r;
        logic [1:0] s_c;
        s_rst = reset;
        s_t = trc_on; s_v = dct_valid; s_c = dct_code; s_f = flush_req; s_r = frame_ready;
        #1;
        if (s_rst) model_reset();
        else model_step(s_t, s_v, s_c, s_f, s_r);
        check("model_buffer", 34'(dct_buffer), 34'(pack_words()));
        check("model_count", 34'(dct_count), 34'(mq.size()));
        check("model_frame_valid", 34'(frame_valid), 34'(m_fv));
        check("model_overflow", 34'(overflow), 34'(m_ovf));
        if (m_fv) check("model_frame_data", frame_data, m_fd);
    end

    // ---------------- driver ----------------
    task automatic step(input logic t, input logic v, input logic [1:0] c,
                        input logic f, input logic r);
        trc_on = t; dct_valid = v; dct_code = c; flush_req = f; frame_ready = r;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buffer"}, 34'(dct_buffer), 34'd0);
        check({tag, "_count"}, 34'(dct_count), 34'd0);
        check({tag, "_frame_valid"}, 34'(frame_valid), 34'd0);
        check({tag, "_frame_data"}, frame_data, 34'd0);
        check({tag, "_overflow"}, 34'(overflow), 34'd0);
    endtask

    initial begin
        reset = 1'b1; trc_on = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
        flush_req = 1'b0; frame_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        step(1, 0, 2'b00, 0, 1);

        // 15 taken codes fill the word, then it transfers.
        repeat (15) step(1, 1, 2'b01, 0, 1);
        check("fill_count", 34'(dct_count), 34'd15);
        check("fill_buffer", 34'(dct_buffer), 34'h15555555);
        step(1, 0, 2'b00, 0, 1);
        check("full_fv", 34'(frame_valid), 34'd1);
        check("full_frame", frame_data, 34'h3D5555555);
        check("full_count", 34'(dct_count), 34'd0);
        step(1, 0, 2'b00, 0, 1);
        check("full_drain", 34'(frame_valid), 34'd0);

        // Flush of an empty word emits nothing.
        step(1, 0, 2'b00, 1, 1);
        check("empty_flush_fv", 34'(frame_valid), 34'd0);

        // Partial flush via flush_req.
        step(1, 1, 2'b01, 0, 1);
        step(1, 1, 2'b10, 0, 1);
        step(1, 1, 2'b11, 0, 1);
        step(1, 0, 2'b00, 1, 1);
        check("flush3_fv", 34'(frame_valid), 34'd1);
        check("flush3_frame", frame_data, 34'h0C000001B);
        step(1, 0, 2'b00, 0, 1);

        // trc_on falling flushes five codes; later codes are ignored.
        step(1, 1, 2'b01, 0, 1);
        step(1, 1, 2'b01, 0, 1);
        step(1, 1, 2'b10, 0, 1);
        step(1, 1, 2'b10, 0, 1);
        step(1, 1, 2'b11, 0, 1);
        step(0, 1, 2'b01, 0, 1);
        check("trcoff_fv", 34'(frame_valid), 34'd1);
        check("trcoff_frame", frame_data, 34'h14000016B);
        check("trcoff_count", 34'(dct_count), 34'd0);
        repeat (3) step(0, 1, 2'b01, 0, 1);
        check("trcoff_ignored", 34'(dct_count), 34'd0);

        // Downstream stalled: 31 codes, second word stalls full, last code dropped.
        step(1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 31; i++) begin
            step(1, 1, 2'(i % 4), 0, 0);
            if (i == 14) check("stall_count15", 34'(dct_count), 34'd15);
            if (i == 15) begin
                check("stall_frame1", frame_data, 34'h3C6C6C6C6);
                check("stall_count1", 34'(dct_count), 34'd1);
            end
            if (i == 29) check("stall_no_ovf_yet", 34'(overflow), 34'd0);
        end
        check("stall_ovf", 34'(overflow), 34'd1);
        check("stall_hold_count", 34'(dct_count), 34'd15);
        check("stall_hold_buffer", 34'(dct_buffer), 34'h31B1B1B1);
        check("stall_frame_stable", frame_data, 34'h3C6C6C6C6);
        step(1, 0, 2'b00, 0, 1);
        check("drain_frame2", frame_data, 34'h3F1B1B1B1);
        check("drain_fv2", 34'(frame_valid), 34'd1);
        step(1, 0, 2'b00, 0, 1);
        check("drain_done", 34'(frame_valid), 34'd0);

        // Flush while busy stays pending and keeps collecting codes.
        step(1, 1, 2'b01, 0, 0);
        step(1, 0, 2'b00, 1, 0);
        check("pend_first", frame_data, 34'h040000001);
        step(1, 1, 2'b10, 0, 0);
        step(1, 1, 2'b11, 1, 0);
        step(1, 1, 2'b00, 0, 0);
        step(1, 1, 2'b01, 0, 0);
        check("pend_hold", frame_data, 34'h040000001);
        check("pend_count", 34'(dct_count), 34'd4);
        step(1, 0, 2'b00, 0, 1);
        check("pend_emit", frame_data, 34'h1000000B1);
        check("pend_cleared", 34'(dct_count), 34'd0);
        step(1, 0, 2'b00, 0, 1);

        // Count 14, busy register, then transfer with a code in the same cycle.
        step(1, 1, 2'b01, 1, 0);
        repeat (14) step(1, 1, 2'b01, 0, 0);
        step(1, 1, 2'b11, 0, 0);
        check("busy_count15", 34'(dct_count), 34'd15);
        check("busy_buffer", 34'(dct_buffer), 34'h15555557);
        step(1, 1, 2'b10, 0, 1);
        check("xfer_count1", 34'(dct_count), 34'd1);
        check("xfer_buffer", 34'(dct_buffer), 34'h2);
        check("xfer_frame", frame_data, 34'h3D5555557);

        // Reset with a held frame and seven codes.
        step(1, 0, 2'b00, 0, 0);
        repeat (6) step(1, 1, 2'b01, 0, 0);
        check("prerst_count", 34'(dct_count), 34'd7);
        check("prerst_fv", 34'(frame_valid), 34'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 2'b00, 0, 1);
        step(1, 0, 2'b00, 0, 1);
        check("postrst_fv", 34'(frame_valid), 34'd0);
        check("postrst_count", 34'(dct_count), 34'd0);

        // Mixed traffic checked against the model.
        repeat (300) begin
            step(logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 2) != 0));
        end

        step(1, 0, 2'b00, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
